axi_read_channel_mux: RTL and testbench
=======================================

# axi_read_channel_mux

Downstream companion to the two-master AXI read arbiter. Takes the arbiter's one-hot grant, accepts the granted master's AR request into a holding register, and forwards it to the single slave port. It then locks the route and steers the R channel back to the owning master until the RLAST beat completes. It also emits the handshake pulse that advances the arbiter's round-robin priority.

## Interface
- ADDR_W, 32, AR address width
- ID_W, 4, ARID/RID width
- DATA_W, 32, RDATA width
- TIMEOUT_CYCLES, 256, idle-R watchdog limit; used only with AXI_MUX_TIMEOUT_EN
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- grant_m0, grant_m1  in  1 each  one-hot grant from the arbiter
- handshake  out  1  one-cycle pulse on master AR acceptance, to the arbiter
- m0_araddr, m1_araddr  in  ADDR_W  master AR address
- m0_arid, m1_arid  in  ID_W  master AR ID
- m0_arlen, m1_arlen  in  8  master burst length minus one
- m0_arvalid, m1_arvalid  in  1  master AR valid
- m0_arready, m1_arready  out  1  master AR ready
- s_araddr / s_arid / s_arlen  out  ADDR_W / ID_W / 8  slave AR payload, registered
- s_arvalid  out  1  slave AR valid
- s_arready  in  1  slave AR ready
- s_rdata / s_rid / s_rresp / s_rlast / s_rvalid  in  DATA_W / ID_W / 2 / 1 / 1  slave R channel
- s_rready  out  1  slave R ready
- m0_r*, m1_r* (rdata, rid, rresp, rlast, rvalid)  out  as slave  per-master R channel
- m0_rready, m1_rready  in  1  per-master R ready
- busy  out  1  high in ADDR or DATA

## Operation
- State: IDLE, ADDR, DATA. Also held: 1-bit owner and the AR payload register.
- IDLE:
  - mX_arready = grant_mX. If grant_mX & mX_arvalid: capture mX payload, owner <= X, handshake = 1 (combinational), go to ADDR.
  - If both grants are high (illegal), M0 wins and m1_arready is forced 0.
  - A grant without arvalid is ignored and the block stays in IDLE.
- ADDR:
  - s_arvalid = 1 with the registered payload, held stable until s_arready.
  - On s_arvalid & s_arready, go to DATA.
  - Both m*_arready = 0.
- DATA:
  - m{owner}_r* = s_r*; m{owner}_rvalid = s_rvalid; s_rready = m{owner}_rready.
  - The non-owner's rvalid = 0.
  - On s_rvalid & s_rready & s_rlast, go to IDLE.
- Outside DATA: s_rready = 0 and all m*_rvalid = 0.
- R beats are passed through unmodified. No beat counting; RLAST alone ends the burst.

## Timing
- Reset, synchronous and dominant over all inputs, gives:
  - state IDLE, owner 0, payload register 0
  - s_arvalid 0, s_rready 0, m*_rvalid 0, busy 0
- handshake is combinational and 0 while rst is high. m*_arready follows the grant only in IDLE and is 0 while rst is high.
- Master AR accepted in cycle N gives s_arvalid high in cycle N+1.
- The R path is purely combinational: 0 cycles of latency, no buffering.
- The cycle after the RLAST handshake is IDLE, so a new grant can be accepted there. The minimum gap between bursts is 1 cycle.
- Reset asserted mid-ADDR or mid-DATA abandons the transaction. The slave is expected to be reset alongside.

## Configuration
- Macro AXI_MUX_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to DATA and on every R handshake, and increments on every other DATA cycle.
  - When it reaches TIMEOUT_CYCLES-1, the block drives one synthetic beat to the owner: rvalid=1, rresp=2'b10 (SLVERR), rlast=1, rid=captured ARID, rdata=0. s_rready is held 0 during that beat.
  - When the owner accepts the beat, the block goes to IDLE.
- Undefined: no counter, no synthetic beat. DATA waits for RLAST indefinitely.

## Test plan
- Reset: hold rst for 3 cycles with arvalid and grant high -> all valids, readies, busy and handshake 0.
- Single read: grant_m0 + m0_arvalid, addr 0x1000, id 3, len 3 -> handshake pulse in cycle N, s_arvalid with 0x1000/3/3 in N+1, 4 beats delivered to M0 only, IDLE after the beat with s_rlast set.
- Slave backpressure: s_arready low for 5 cycles -> s_arvalid and payload stable for the whole wait, no second handshake.
- Alternation: both masters requesting with the arbiter toggling -> bursts ordered M0, M1, M0; M1's R beats (id 5) never appear on M0.
- Master R backpressure: m1_rready low mid-burst -> s_rready low, beat held, no beat lost or duplicated.
- Timeout (macro on, TIMEOUT_CYCLES=8): AR accepted, no R for 8 cycles -> one SLVERR beat with rlast and captured ID, then IDLE; with the macro off, still in DATA after 100 cycles.

Source files
------------

// File: rtl/axi_read_channel_mux.sv
// axi_read_channel_mux
// Sits behind the two-master AXI read arbiter. Accepts the granted master's
// AR request into a holding register, forwards it to the single slave port,
// then locks the route and steers the R channel back to the owning master
// until the RLAST beat completes. The handshake output is the pulse that
// advances the arbiter's round-robin priority.
//
// Optional feature: define AXI_MUX_TIMEOUT_EN to enable an idle-R watchdog.
// It answers a silent slave with one synthetic SLVERR/RLAST beat after
// TIMEOUT_CYCLES quiet DATA cycles.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a granted master with arvalid; arready = grant
// ADDR  | registered AR payload presented to the slave until s_arready
// DATA  | R channel routed to the owner until the RLAST handshake
module axi_read_channel_mux #(
    parameter int ADDR_W         = 32,
    parameter int ID_W           = 4,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              grant_m0,
    input  logic              grant_m1,
    output logic              handshake,
    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic [ID_W-1:0]   m0_arid,
    input  logic [7:0]        m0_arlen,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic [ID_W-1:0]   m1_arid,
    input  logic [7:0]        m1_arlen,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    output logic [ADDR_W-1:0] s_araddr,
    output logic [ID_W-1:0]   s_arid,
    output logic [7:0]        s_arlen,
    output logic              s_arvalid,
    input  logic              s_arready,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [ID_W-1:0]   s_rid,
    input  logic [1:0]        s_rresp,
    input  logic              s_rlast,
    input  logic              s_rvalid,
    output logic              s_rready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [ID_W-1:0]   m0_rid,
    output logic [1:0]        m0_rresp,
    output logic              m0_rlast,
    output logic              m0_rvalid,
    input  logic              m0_rready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ID_W-1:0]   m1_rid,
    output logic [1:0]        m1_rresp,
    output logic              m1_rlast,
    output logic              m1_rvalid,
    input  logic              m1_rready,
    output logic              busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    logic [1:0]        state;
    logic              owner;
    logic [ADDR_W-1:0] pl_addr;
    logic [ID_W-1:0]   pl_id;
    logic [7:0]        pl_len;

    logic              in_idle;
    logic              in_data;
    logic              accept0;
    logic              accept1;
    logic              owner_rready;
    logic              r_hs;
    logic              r_done;
    logic              timeout_beat;

    logic [DATA_W-1:0] r_data;
    logic [ID_W-1:0]   r_id;
    logic [1:0]        r_resp;
    logic              r_last;
    logic              r_valid;

    assign in_idle = (state == IDLE);
    assign in_data = (state == DATA);

    // M0 wins an illegal double grant, so m1_arready is masked by grant_m0.
    assign m0_arready = ~rst & in_idle & grant_m0;
    assign m1_arready = ~rst & in_idle & grant_m1 & ~grant_m0;
    assign accept0    = m0_arready & m0_arvalid;
    assign accept1    = m1_arready & m1_arvalid;
    assign handshake  = accept0 | accept1;

    assign s_arvalid = (state == ADDR);
    assign s_araddr  = pl_addr;
    assign s_arid    = pl_id;
    assign s_arlen   = pl_len;
    assign busy      = (state == ADDR) | in_data;

    assign owner_rready = owner ? m1_rready : m0_rready;
    assign r_hs         = s_rvalid & s_rready;

`ifdef AXI_MUX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] tmo_cnt;

    assign timeout_beat = in_data & (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign r_done       = (r_hs & s_rlast) | (timeout_beat & owner_rready);

    // Quiet-cycle counter: restarts on DATA entry and on every R beat,
    // and parks at the limit while the synthetic beat waits for the owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if ((state == ADDR) && s_arready) begin
            tmo_cnt <= '0;
        end else if (in_data) begin
            if (r_hs) begin
                tmo_cnt <= '0;
            end else if (!timeout_beat) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end
`else
    // No watchdog: the burst ends only on RLAST. TIMEOUT_CYCLES is referenced
    // here so the parameter stays tied in this build; the result is always 0.
    assign timeout_beat = (TIMEOUT_CYCLES < 0);
    assign r_done       = r_hs & s_rlast;
`endif

    // R-path steering: pass-through from the slave, or the synthetic error beat.
    always_comb begin
        r_data   = s_rdata;
        r_id     = s_rid;
        r_resp   = s_rresp;
        r_last   = s_rlast;
        r_valid  = in_data & s_rvalid;
        s_rready = in_data & owner_rready;
        if (timeout_beat) begin
            r_data   = '0;
            r_id     = pl_id;
            r_resp   = 2'b10;
            r_last   = 1'b1;
            r_valid  = 1'b1;
            s_rready = 1'b0;
        end
    end

    // Payload lines go to both masters; only the owner sees rvalid.
    assign m0_rdata  = r_data;
    assign m0_rid    = r_id;
    assign m0_rresp  = r_resp;
    assign m0_rlast  = r_last;
    assign m0_rvalid = r_valid & ~owner;
    assign m1_rdata  = r_data;
    assign m1_rid    = r_id;
    assign m1_rresp  = r_resp;
    assign m1_rlast  = r_last;
    assign m1_rvalid = r_valid & owner;

    // Sequencing FSM with the AR holding register and route owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            owner   <= 1'b0;
            pl_addr <= '0;
            pl_id   <= '0;
            pl_len  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept0) begin
                        pl_addr <= m0_araddr;
                        pl_id   <= m0_arid;
                        pl_len  <= m0_arlen;
                        owner   <= 1'b0;
                        state   <= ADDR;
                    end else if (accept1) begin
                        pl_addr <= m1_araddr;
                        pl_id   <= m1_arid;
                        pl_len  <= m1_arlen;
                        owner   <= 1'b1;
                        state   <= ADDR;
                    end
                end
                ADDR: begin
                    if (s_arready) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (r_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_read_channel_mux.sv
// Directed bench for axi_read_channel_mux. Inputs change on the falling edge,
// and outputs are sampled 1 ns later, well away from the rising edge.
// Build with or without AXI_MUX_TIMEOUT_EN; the timeout scenario adapts.
module tb_axi_read_channel_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic        grant_m0, grant_m1;
    logic        handshake;
    logic [31:0] m0_araddr, m1_araddr;
    logic [3:0]  m0_arid, m1_arid;
    logic [7:0]  m0_arlen, m1_arlen;
    logic        m0_arvalid, m1_arvalid, m0_arready, m1_arready;
    logic [31:0] s_araddr;
    logic [3:0]  s_arid;
    logic [7:0]  s_arlen;
    logic        s_arvalid, s_arready;
    logic [31:0] s_rdata;
    logic [3:0]  s_rid;
    logic [1:0]  s_rresp;
    logic        s_rlast, s_rvalid, s_rready;
    logic [31:0] m0_rdata, m1_rdata;
    logic [3:0]  m0_rid, m1_rid;
    logic [1:0]  m0_rresp, m1_rresp;
    logic        m0_rlast, m1_rlast, m0_rvalid, m1_rvalid, m0_rready, m1_rready;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axi_read_channel_mux #(
        .ADDR_W(32), .ID_W(4), .DATA_W(32), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .grant_m0(grant_m0), .grant_m1(grant_m1), .handshake(handshake),
        .m0_araddr(m0_araddr), .m0_arid(m0_arid), .m0_arlen(m0_arlen),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m1_araddr(m1_araddr), .m1_arid(m1_arid), .m1_arlen(m1_arlen),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rid(s_rid), .s_rresp(s_rresp),
        .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m0_rdata(m0_rdata), .m0_rid(m0_rid), .m0_rresp(m0_rresp),
        .m0_rlast(m0_rlast), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_rdata(m1_rdata), .m1_rid(m1_rid), .m1_rresp(m1_rresp),
        .m1_rlast(m1_rlast), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .busy(busy)
    );

    task automatic test_reset();
        rst = 1'b1;
        grant_m0 = 1'b1; grant_m1 = 1'b1; m0_arvalid = 1'b1; m1_arvalid = 1'b1;
        m0_araddr = 32'h0; m1_araddr = 32'h0; m0_arid = 4'd0; m1_arid = 4'd0;
        m0_arlen = 8'd0; m1_arlen = 8'd0;
        s_arready = 1'b1; s_rvalid = 1'b1; s_rlast = 1'b1; s_rdata = 32'h0;
        s_rid = 4'd0; s_rresp = 2'b00; m0_rready = 1'b1; m1_rready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            checks++;
            if ({handshake, m0_arready, m1_arready, s_arvalid, s_rready,
                 m0_rvalid, m1_rvalid, busy} !== 8'b0) begin
                failures++;
                $display("FAIL reset_outputs cycle=%0d got hs=%b ar0=%b ar1=%b sav=%b srr=%b rv0=%b rv1=%b busy=%b exp=all 0",
                         c, handshake, m0_arready, m1_arready, s_arvalid, s_rready,
                         m0_rvalid, m1_rvalid, busy);
            end
        end
        @(negedge clk);
        rst = 1'b0; grant_m0 = 1'b0; grant_m1 = 1'b0;
        m0_arvalid = 1'b0; m1_arvalid = 1'b0; s_arready = 1'b0;
        s_rvalid = 1'b0; s_rlast = 1'b0;
        #1;
        checks++;
        if ({busy, s_arvalid} !== 2'b00) begin
            failures++;
            $display("FAIL reset_release got busy=%b sav=%b exp=0 0", busy, s_arvalid);
        end
    endtask

    task automatic test_single_read();
        @(negedge clk);
        grant_m0 = 1'b1; m0_arvalid = 1'b1;
        m0_araddr = 32'h1000; m0_arid = 4'd3; m0_arlen = 8'd3;
        #1;
        checks++;
        if ({handshake, m0_arready, m1_arready, s_arvalid} !== 4'b1100) begin
            failures++;
            $display("FAIL single_accept got hs=%b ar0=%b ar1=%b sav=%b exp=1 1 0 0",
                     handshake, m0_arready, m1_arready, s_arvalid);
        end
        @(negedge clk);
        grant_m0 = 1'b0; m0_arvalid = 1'b0;
        m0_araddr = 32'hDEAD_BEEF; m0_arid = 4'hF; m0_arlen = 8'hFF; s_arready = 1'b1;
        #1;
        checks++;
        if ({s_arvalid, handshake, busy, s_araddr, s_arid, s_arlen} !==
            {1'b1, 1'b0, 1'b1, 32'h1000, 4'd3, 8'd3}) begin
            failures++;
            $display("FAIL single_slave_ar got sav=%b hs=%b busy=%b addr=%h id=%0d len=%0d exp=1 0 1 00001000 3 3",
                     s_arvalid, handshake, busy, s_araddr, s_arid, s_arlen);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            s_arready = 1'b0; s_rvalid = 1'b1; s_rdata = 32'hA000 + 32'(i);
            s_rid = 4'd3; s_rresp = 2'b00; s_rlast = (i == 3); m0_rready = 1'b1;
            #1;
            checks++;
            if ({m0_rvalid, m1_rvalid, s_rready, m0_rdata, m0_rid, m0_rlast} !==
                {1'b1, 1'b0, 1'b1, 32'hA000 + 32'(i), 4'd3, (i == 3)}) begin
                failures++;
                $display("FAIL single_beat%0d got rv0=%b rv1=%b srr=%b data=%h id=%0d last=%b exp=1 0 1 %h 3 %b",
                         i, m0_rvalid, m1_rvalid, s_rready, m0_rdata, m0_rid, m0_rlast,
                         32'hA000 + 32'(i), (i == 3));
            end
        end
        @(negedge clk);
        s_rvalid = 1'b0; s_rlast = 1'b0;
        #1;
        checks++;
        if ({busy, m0_rvalid, s_rready} !== 3'b000) begin
            failures++;
            $display("FAIL single_idle got busy=%b rv0=%b srr=%b exp=0 0 0", busy, m0_rvalid, s_rready);
        end
    endtask

    task automatic test_both_grants();
        @(negedge clk);
        grant_m0 = 1'b1; grant_m1 = 1'b1; m0_arvalid = 1'b0; m1_arvalid = 1'b1;
        m1_araddr = 32'h7777; m1_arid = 4'd7;
        #1;
        checks++;
        if ({m0_arready, m1_arready, handshake} !== 3'b100) begin
            failures++;
            $display("FAIL dual_grant_no_m0 got ar0=%b ar1=%b hs=%b exp=1 0 0", m0_arready, m1_arready, handshake);
        end
        @(negedge clk);
        m0_arvalid = 1'b1; m0_araddr = 32'h0ABC; m0_arid = 4'd1; m0_arlen = 8'd0;
        #1;
        checks++;
        if ({busy, handshake, m0_arready, m1_arready} !== 4'b0110) begin
            failures++;
            $display("FAIL dual_grant_m0_wins got busy=%b hs=%b ar0=%b ar1=%b exp=0 1 1 0",
                     busy, handshake, m0_arready, m1_arready);
        end
        @(negedge clk);
        grant_m0 = 1'b0; grant_m1 = 1'b0; m0_arvalid = 1'b0; m1_arvalid = 1'b0; s_arready = 1'b1;
        #1;
        checks++;
        if ({s_araddr, s_arid} !== {32'h0ABC, 4'd1}) begin
            failures++;
            $display("FAIL dual_grant_payload got addr=%h id=%0d exp=00000abc 1", s_araddr, s_arid);
        end
        @(negedge clk);
        s_arready = 1'b0; s_rvalid = 1'b1; s_rlast = 1'b1; s_rid = 4'd1; s_rdata = 32'h11;
        #1;
        checks++;
        if ({m0_rvalid, m1_rvalid} !== 2'b10) begin
            failures++;
            $display("FAIL dual_grant_route got rv0=%b rv1=%b exp=1 0", m0_rvalid, m1_rvalid);
        end
        @(negedge clk);
        s_rvalid = 1'b0; s_rlast = 1'b0;
    endtask

    task automatic test_ar_backpressure();
        @(negedge clk);
        grant_m1 = 1'b1; m1_arvalid = 1'b1;
        m1_araddr = 32'h2000; m1_arid = 4'd5; m1_arlen = 8'd0; s_arready = 1'b0;
        #1;
        checks++;
        if ({handshake, m0_arready, m1_arready} !== 3'b101) begin
            failures++;
            $display("FAIL bp_accept got hs=%b ar0=%b ar1=%b exp=1 0 1", handshake, m0_arready, m1_arready);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            m1_araddr = 32'h3000 + 32'(c); m1_arid = 4'd6; m1_arlen = 8'd9;
            #1;
            checks++;
            if ({s_arvalid, handshake, m1_arready, s_araddr, s_arid, s_arlen} !==
                {1'b1, 1'b0, 1'b0, 32'h2000, 4'd5, 8'd0}) begin
                failures++;
                $display("FAIL bp_hold%0d got sav=%b hs=%b ar1=%b addr=%h id=%0d len=%0d exp=1 0 0 00002000 5 0",
                         c, s_arvalid, handshake, m1_arready, s_araddr, s_arid, s_arlen);
            end
        end
        @(negedge clk);
        grant_m1 = 1'b0; m1_arvalid = 1'b0; s_arready = 1'b1;
        @(negedge clk);
        s_arready = 1'b0; s_rvalid = 1'b1; s_rlast = 1'b1; s_rid = 4'd5; s_rdata = 32'h55;
        #1;
        checks++;
        if ({m1_rvalid, m0_rvalid, m1_rid, m1_rdata} !== {1'b1, 1'b0, 4'd5, 32'h55}) begin
            failures++;
            $display("FAIL bp_beat got rv1=%b rv0=%b id=%0d data=%h exp=1 0 5 00000055",
                     m1_rvalid, m0_rvalid, m1_rid, m1_rdata);
        end
        @(negedge clk);
        s_rvalid = 1'b0; s_rlast = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_idle got busy=%b exp=0", busy);
        end
    endtask

    task automatic test_alternation();
        int order [3] = '{0, 1, 0};
        int beats [3] = '{2, 2, 1};
        int m;
        logic [3:0] id;
        for (int b = 0; b < 3; b++) begin
            m  = order[b];
            id = (m == 1) ? 4'd5 : 4'd2;
            @(negedge clk);
            s_rvalid = 1'b0; s_rlast = 1'b0;
            grant_m0 = (m == 0); grant_m1 = (m == 1);
            m0_arvalid = 1'b1; m1_arvalid = 1'b1;
            m0_arid = 4'd2; m1_arid = 4'd5;
            m0_araddr = 32'h4000 + 32'(b); m1_araddr = 32'h8000 + 32'(b);
            #1;
            checks++;
            if ({busy, handshake, m0_arready, m1_arready} !== {1'b0, 1'b1, (m == 0), (m == 1)}) begin
                failures++;
                $display("FAIL alt_accept%0d got busy=%b hs=%b ar0=%b ar1=%b exp=0 1 %b %b",
                         b, busy, handshake, m0_arready, m1_arready, (m == 0), (m == 1));
            end
            @(negedge clk);
            grant_m0 = 1'b0; grant_m1 = 1'b0; s_arready = 1'b1;
            #1;
            checks++;
            if ({s_arvalid, s_arid, s_araddr} !==
                {1'b1, id, (m == 1) ? 32'h8000 + 32'(b) : 32'h4000 + 32'(b)}) begin
                failures++;
                $display("FAIL alt_ar%0d got sav=%b id=%0d addr=%h exp=1 %0d from M%0d",
                         b, s_arvalid, s_arid, s_araddr, id, m);
            end
            for (int k = 0; k < beats[b]; k++) begin
                @(negedge clk);
                s_arready = 1'b0; s_rvalid = 1'b1; s_rid = id;
                s_rdata = 32'(b * 16 + k); s_rlast = (k == beats[b] - 1);
                #1;
                checks++;
                if ({m0_rvalid, m1_rvalid, s_rready} !== {(m == 0), (m == 1), 1'b1}) begin
                    failures++;
                    $display("FAIL alt_route%0d_%0d got rv0=%b rv1=%b srr=%b exp=%b %b 1",
                             b, k, m0_rvalid, m1_rvalid, s_rready, (m == 0), (m == 1));
                end
            end
        end
        @(negedge clk);
        s_rvalid = 1'b0; s_rlast = 1'b0; m0_arvalid = 1'b0; m1_arvalid = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL alt_idle got busy=%b exp=0", busy);
        end
    endtask

    task automatic test_r_backpressure();
        logic rdy_tab [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int beat = 0;
        int accepted = 0;
        @(negedge clk);
        grant_m1 = 1'b1; m1_arvalid = 1'b1; m1_arid = 4'd5; m1_arlen = 8'd2; m1_araddr = 32'h9000;
        @(negedge clk);
        grant_m1 = 1'b0; m1_arvalid = 1'b0; s_arready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            s_arready = 1'b0; s_rvalid = 1'b1; s_rid = 4'd5;
            s_rdata = 32'h100 + 32'(beat); s_rlast = (beat == 2); m1_rready = rdy_tab[c];
            #1;
            checks++;
            if ({s_rready, m1_rvalid, m0_rvalid, m1_rdata} !==
                {rdy_tab[c], 1'b1, 1'b0, 32'h100 + 32'(beat)}) begin
                failures++;
                $display("FAIL rbp_cycle%0d got srr=%b rv1=%b rv0=%b data=%h exp=%b 1 0 %h",
                         c, s_rready, m1_rvalid, m0_rvalid, m1_rdata, rdy_tab[c], 32'h100 + 32'(beat));
            end
            if (m1_rvalid && m1_rready && s_rready) accepted++;
            if (rdy_tab[c]) beat++;
        end
        checks++;
        if (accepted !== 3) begin
            failures++;
            $display("FAIL rbp_beat_count got=%0d exp=3", accepted);
        end
        @(negedge clk);
        s_rvalid = 1'b0; s_rlast = 1'b0; m1_rready = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL rbp_idle got busy=%b exp=0", busy);
        end
    endtask

    task automatic test_timeout();
        @(negedge clk);
        grant_m0 = 1'b1; m0_arvalid = 1'b1; m0_arid = 4'd9; m0_arlen = 8'd0; m0_araddr = 32'hC000;
        @(negedge clk);
        grant_m0 = 1'b0; m0_arvalid = 1'b0; s_arready = 1'b1;
        s_rdata = 32'hFFFF_FFFF; s_rresp = 2'b00; s_rid = 4'd0; s_rlast = 1'b0;
`ifdef AXI_MUX_TIMEOUT_EN
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            s_arready = 1'b0; s_rvalid = 1'b0; m0_rready = 1'b1;
            #1;
            checks++;
            if (k < 7) begin
                if ({m0_rvalid, busy} !== 2'b01) begin
                    failures++;
                    $display("FAIL tmo_quiet%0d got rv0=%b busy=%b exp=0 1", k, m0_rvalid, busy);
                end
            end else begin
                if ({m0_rvalid, m0_rresp, m0_rlast, m0_rid, m0_rdata, s_rready, m1_rvalid} !==
                    {1'b1, 2'b10, 1'b1, 4'd9, 32'd0, 1'b0, 1'b0}) begin
                    failures++;
                    $display("FAIL tmo_beat got rv0=%b resp=%b last=%b id=%0d data=%h srr=%b rv1=%b exp=1 10 1 9 00000000 0 0",
                             m0_rvalid, m0_rresp, m0_rlast, m0_rid, m0_rdata, s_rready, m1_rvalid);
                end
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if ({busy, m0_rvalid} !== 2'b00) begin
            failures++;
            $display("FAIL tmo_idle got busy=%b rv0=%b exp=0 0", busy, m0_rvalid);
        end
`else
        @(negedge clk);
        s_arready = 1'b0; s_rvalid = 1'b0; m0_rready = 1'b1;
        repeat (100) @(negedge clk);
        #1;
        checks++;
        if ({busy, m0_rvalid, s_rready} !== 3'b101) begin
            failures++;
            $display("FAIL no_tmo_wait got busy=%b rv0=%b srr=%b exp=1 0 1", busy, m0_rvalid, s_rready);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({busy, s_arvalid, m0_rvalid} !== 3'b000) begin
            failures++;
            $display("FAIL mid_data_reset got busy=%b sav=%b rv0=%b exp=0 0 0", busy, s_arvalid, m0_rvalid);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "bench time limit");
    end

    initial begin
        test_reset();
        test_single_read();
        test_both_grants();
        test_ar_backpressure();
        test_alternation();
        test_r_backpressure();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
